// File: rtl/sca_sched.sv
// Job scheduler for the sparse computing array: streams one beat per (tile, channel),
// generates weight/index addresses and channel markers, and bounds in-flight beats.
module sca_sched #(
   parameter int unsigned WEIGHT_ADDR_W = 12,
   parameter int unsigned INDEX_ADDR_W  = 10,
   parameter int unsigned CH_W          = 6,
   parameter int unsigned TILE_W        = 10,
   parameter int unsigned MAX_INFLIGHT  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_start,
   input  logic                     cfg_abort,
   input  logic [TILE_W-1:0]        cfg_n_tiles,
   input  logic [CH_W-1:0]          cfg_n_ch,
   input  logic [WEIGHT_ADDR_W-1:0] cfg_wbase,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     sca_valid,
   output logic [WEIGHT_ADDR_W-1:0] sca_waddr,
   output logic [INDEX_ADDR_W-1:0]  sca_iaddr,
   output logic                     sca_first,
   output logic                     sca_last,
   output logic [TILE_W-1:0]        sca_tile,
   input  logic                     out_ready,
   input  logic                     sca_valid_out,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int unsigned OUT_W = 4;
   localparam logic [OUT_W-1:0] MAX_C = OUT_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [OUT_W-1:0]         outst_q, outst_d;
   logic [CH_W-1:0]          ch_q, ch_d, n_ch_q, n_ch_d;
   logic [TILE_W-1:0]        tile_q, tile_d, n_tiles_q, n_tiles_d;
   logic [WEIGHT_ADDR_W-1:0] wbase_q, wbase_d;
   logic                     err_q, err_d;
   logic                     accept, fire, retire, ch_last, tile_last, empty_job;

   assign accept    = (state_q == IDLE) & cfg_start & ~cfg_abort;
   assign empty_job = (cfg_n_tiles == '0) | (cfg_n_ch == '0);
   assign fire      = in_valid & in_ready;
   assign retire    = sca_valid_out;
   assign ch_last   = (ch_q == n_ch_q - CH_W'(1));
   assign tile_last = (tile_q == n_tiles_q - TILE_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DRAIN looks at the post-retire count so the final retire exits at once
   always_comb begin
      state_d = state_q;
      if (cfg_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cfg_start) state_d = empty_job ? DONE : RUN;
            RUN:     if (fire && ch_last && tile_last) state_d = DRAIN;
            DRAIN:   if (outst_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      in_ready  = (state_q == RUN) & out_ready & (outst_q < MAX_C);
      sca_valid = fire;
      sca_first = fire & (ch_q == '0);
      sca_last  = fire & ch_last;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

   assign sca_waddr = wbase_q + WEIGHT_ADDR_W'(ch_q);
   assign sca_iaddr = sca_waddr[INDEX_ADDR_W-1:0];
   assign sca_tile  = tile_q;
   assign err       = err_q;

   // Datapath next-state: counters, job config, outstanding-beat tracking, error flag
   always_comb begin
      outst_d   = outst_q;
      ch_d      = ch_q;
      tile_d    = tile_q;
      n_ch_d    = n_ch_q;
      n_tiles_d = n_tiles_q;
      wbase_d   = wbase_q;
      err_d     = err_q;
      if (cfg_abort) begin
         outst_d = '0;
         ch_d    = '0;
         tile_d  = '0;
      end else begin
         case ({fire, retire})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   if (outst_q != '0) outst_d = outst_q - OUT_W'(1);
            2'b11:   if (outst_q == '0) outst_d = OUT_W'(1);
            default: outst_d = outst_q;
         endcase
         if (retire && (outst_q == '0)) err_d = 1'b1;
         if (accept) begin
            err_d     = 1'b0;
            ch_d      = '0;
            tile_d    = '0;
            n_ch_d    = cfg_n_ch;
            n_tiles_d = cfg_n_tiles;
            wbase_d   = cfg_wbase;
         end else if (fire) begin
            if (ch_last) begin
               ch_d   = '0;
               tile_d = tile_q + TILE_W'(1);
            end else begin
               ch_d   = ch_q + CH_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_q   <= '0;
         ch_q      <= '0;
         tile_q    <= '0;
         n_ch_q    <= '0;
         n_tiles_q <= '0;
         wbase_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         outst_q   <= outst_d;
         ch_q      <= ch_d;
         tile_q    <= tile_d;
         n_ch_q    <= n_ch_d;
         n_tiles_q <= n_tiles_d;
         wbase_q   <= wbase_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_sca_sched.sv
// Directed bench for sca_sched: each task drives one scenario cycle by cycle and checks inline.
module tb_sca_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_start, cfg_abort;
   logic [9:0]  cfg_n_tiles;
   logic [5:0]  cfg_n_ch;
   logic [11:0] cfg_wbase;
   logic        in_valid, in_ready, sca_valid;
   logic [11:0] sca_waddr;
   logic [9:0]  sca_iaddr;
   logic        sca_first, sca_last;
   logic [9:0]  sca_tile;
   logic        out_ready, sca_valid_out;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sca_sched #(
      .WEIGHT_ADDR_W(12), .INDEX_ADDR_W(10), .CH_W(6), .TILE_W(10), .MAX_INFLIGHT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_n_tiles(cfg_n_tiles), .cfg_n_ch(cfg_n_ch), .cfg_wbase(cfg_wbase),
      .in_valid(in_valid), .in_ready(in_ready), .sca_valid(sca_valid),
      .sca_waddr(sca_waddr), .sca_iaddr(sca_iaddr),
      .sca_first(sca_first), .sca_last(sca_last), .sca_tile(sca_tile),
      .out_ready(out_ready), .sca_valid_out(sca_valid_out),
      .busy(busy), .done(done), .err(err)
   );

   // Cycle 0 of a job: start is presented in the low phase and accepted at the next rising edge
   task automatic start_job(input logic [9:0] nt, input logic [5:0] nc, input logic [11:0] wb);
      @(negedge clk);
      cfg_start = 1'b1; cfg_abort = 1'b0; in_valid = 1'b0; sca_valid_out = 1'b0; out_ready = 1'b1;
      cfg_n_tiles = nt; cfg_n_ch = nc; cfg_wbase = wb;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_n_tiles = '0; cfg_n_ch = '0;
      cfg_wbase = '0; in_valid = 1'b1; out_ready = 1'b1; sca_valid_out = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if ({in_ready, sca_valid, sca_first, sca_last, busy, done, err} !== 7'b0) begin errors++; $display("FAIL reset_flags c=%0d got %b exp 0000000", c, {in_ready, sca_valid, sca_first, sca_last, busy, done, err}); end
         checks++; if ({sca_waddr, sca_iaddr, sca_tile} !== 32'h0) begin errors++; $display("FAIL reset_addr c=%0d got %h/%h/%h exp 0", c, sca_waddr, sca_iaddr, sca_tile); end
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if ({in_ready, busy, done, err} !== 4'b0) begin errors++; $display("FAIL reset_idle got %b exp 0000", {in_ready, busy, done, err}); end
      in_valid = 1'b0;
   endtask

   task automatic test_basic;
      int b;
      start_job(10'd2, 6'd3, 12'h100);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         cfg_start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sca_valid_out = (c >= 4 && c <= 9);
         #1;
         b = c - 1;
         checks++; if (sca_valid !== (c <= 6)) begin errors++; $display("FAIL basic_fire c=%0d got %b exp %b", c, sca_valid, (c <= 6)); end
         if (c <= 6) begin
            checks++; if (sca_waddr !== 12'h100 + 12'(b % 3)) begin errors++; $display("FAIL basic_waddr c=%0d got %h exp %h", c, sca_waddr, 12'h100 + 12'(b % 3)); end
            checks++; if (sca_iaddr !== 10'h100 + 10'(b % 3)) begin errors++; $display("FAIL basic_iaddr c=%0d got %h exp %h", c, sca_iaddr, 10'h100 + 10'(b % 3)); end
            checks++; if ({sca_first, sca_last} !== {(b % 3 == 0), (b % 3 == 2)}) begin errors++; $display("FAIL basic_marks c=%0d got %b%b exp %b%b", c, sca_first, sca_last, (b % 3 == 0), (b % 3 == 2)); end
            checks++; if (sca_tile !== 10'(b / 3)) begin errors++; $display("FAIL basic_tile c=%0d got %0d exp %0d", c, sca_tile, b / 3); end
         end
         checks++; if (done !== (c == 10)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, done, (c == 10)); end
         checks++; if (busy !== (c <= 10)) begin errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, (c <= 10)); end
      end
      in_valid = 1'b0; sca_valid_out = 1'b0;
   endtask

   task automatic test_inflight;
      int fires = 0;
      start_job(10'd2, 6'd3, 12'h000);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); cfg_start = 1'b0; in_valid = 1'b1; #1;
         if (sca_valid) fires++;
      end
      checks++; if (fires != 4) begin errors++; $display("FAIL inflight_cap got %0d exp 4", fires); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL inflight_ready got %b exp 0", in_ready); end
      fires = 0;
      for (int c = 9; c <= 14; c++) begin
         @(negedge clk); sca_valid_out = (c == 9); #1;
         if (sca_valid) begin
            fires++;
            checks++; if ({sca_tile, sca_waddr} !== {10'd1, 12'h001}) begin errors++; $display("FAIL inflight_beat got t%0d %h exp t1 001", sca_tile, sca_waddr); end
         end
      end
      checks++; if (fires != 1) begin errors++; $display("FAIL inflight_one_more got %0d exp 1", fires); end
      @(negedge clk); cfg_abort = 1'b1; in_valid = 1'b0;
      @(negedge clk); cfg_abort = 1'b0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inflight_abort_busy got %b exp 0", busy); end
   endtask

   task automatic test_stall;
      logic [11:0] exp_wa;
      logic [9:0]  exp_t;
      logic        exp_f;
      start_job(10'd2, 6'd3, 12'h200);
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         cfg_start = 1'b0; in_valid = 1'b1; out_ready = !(c >= 3 && c <= 7);
         sca_valid_out = (c == 3 || c == 4 || (c >= 12 && c <= 15));
         #1;
         exp_f = (c == 1 || c == 2 || (c >= 8 && c <= 11));
         case (c)
            1:       begin exp_wa = 12'h200; exp_t = 10'd0; end
            2:       begin exp_wa = 12'h201; exp_t = 10'd0; end
            9:       begin exp_wa = 12'h200; exp_t = 10'd1; end
            10:      begin exp_wa = 12'h201; exp_t = 10'd1; end
            11:      begin exp_wa = 12'h202; exp_t = 10'd1; end
            default: begin exp_wa = 12'h202; exp_t = 10'd0; end
         endcase
         checks++; if (sca_valid !== exp_f) begin errors++; $display("FAIL stall_fire c=%0d got %b exp %b", c, sca_valid, exp_f); end
         if (c <= 11) begin
            checks++; if ({sca_tile, sca_waddr} !== {exp_t, exp_wa}) begin errors++; $display("FAIL stall_addr c=%0d got t%0d %h exp t%0d %h", c, sca_tile, sca_waddr, exp_t, exp_wa); end
         end
         checks++; if (done !== (c == 16)) begin errors++; $display("FAIL stall_done c=%0d got %b exp %b", c, done, (c == 16)); end
      end
      in_valid = 1'b0; sca_valid_out = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_wrap;
      logic [11:0] wa [4];
      wa[0] = 12'hFFE; wa[1] = 12'hFFF; wa[2] = 12'h000; wa[3] = 12'h001;
      start_job(10'd1, 6'd4, 12'hFFE);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         cfg_start = 1'b0; in_valid = 1'b1; sca_valid_out = (c >= 2 && c <= 5);
         #1;
         checks++; if (sca_valid !== (c <= 4)) begin errors++; $display("FAIL wrap_fire c=%0d got %b exp %b", c, sca_valid, (c <= 4)); end
         if (c <= 4) begin
            checks++; if (sca_waddr !== wa[c-1]) begin errors++; $display("FAIL wrap_waddr c=%0d got %h exp %h", c, sca_waddr, wa[c-1]); end
            checks++; if (sca_iaddr !== wa[c-1][9:0]) begin errors++; $display("FAIL wrap_iaddr c=%0d got %h exp %h", c, sca_iaddr, wa[c-1][9:0]); end
            checks++; if ({sca_first, sca_last} !== {(c == 1), (c == 4)}) begin errors++; $display("FAIL wrap_marks c=%0d got %b%b exp %b%b", c, sca_first, sca_last, (c == 1), (c == 4)); end
         end
         checks++; if (done !== (c == 6)) begin errors++; $display("FAIL wrap_done c=%0d got %b exp %b", c, done, (c == 6)); end
      end
      in_valid = 1'b0; sca_valid_out = 1'b0;
   endtask

   task automatic test_empty_err;
      start_job(10'd5, 6'd0, 12'h040);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         in_valid = 1'b1; sca_valid_out = (c == 3); cfg_start = (c == 6);
         if (c == 6) begin cfg_n_tiles = 10'd0; cfg_n_ch = 6'd2; end
         else cfg_start = 1'b0;
         #1;
         checks++; if (sca_valid !== 1'b0) begin errors++; $display("FAIL empty_fire c=%0d got %b exp 0", c, sca_valid); end
         checks++; if (done !== (c == 1 || c == 7)) begin errors++; $display("FAIL empty_done c=%0d got %b exp %b", c, done, (c == 1 || c == 7)); end
         checks++; if (busy !== (c == 1 || c == 7)) begin errors++; $display("FAIL empty_busy c=%0d got %b exp %b", c, busy, (c == 1 || c == 7)); end
         checks++; if (err !== (c >= 4 && c <= 6)) begin errors++; $display("FAIL empty_err c=%0d got %b exp %b", c, err, (c >= 4 && c <= 6)); end
      end
      cfg_start = 1'b0; in_valid = 1'b0; sca_valid_out = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort;
      logic [11:0] exp_wa;
      start_job(10'd1, 6'd4, 12'h010);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         cfg_start = (c == 7); cfg_abort = (c == 3);
         in_valid = (c <= 2 || c >= 8); sca_valid_out = (c == 5 || c == 9 || c == 10);
         if (c == 7) begin cfg_n_tiles = 10'd1; cfg_n_ch = 6'd2; cfg_wbase = 12'h030; end
         #1;
         checks++; if (sca_valid !== (c <= 2 || c == 8 || c == 9)) begin errors++; $display("FAIL abort_fire c=%0d got %b exp %b", c, sca_valid, (c <= 2 || c == 8 || c == 9)); end
         checks++; if (busy !== (c <= 3 || c >= 8)) begin errors++; $display("FAIL abort_busy c=%0d got %b exp %b", c, busy, (c <= 3 || c >= 8)); end
         checks++; if (done !== (c == 11)) begin errors++; $display("FAIL abort_done c=%0d got %b exp %b", c, done, (c == 11)); end
         checks++; if (err !== (c == 6 || c == 7)) begin errors++; $display("FAIL abort_err c=%0d got %b exp %b", c, err, (c == 6 || c == 7)); end
         if (c == 4) begin
            checks++; if ({sca_tile, sca_waddr} !== {10'd0, 12'h010}) begin errors++; $display("FAIL abort_cleared got t%0d %h exp t0 010", sca_tile, sca_waddr); end
         end
         if (c == 8 || c == 9) begin
            exp_wa = (c == 8) ? 12'h030 : 12'h031;
            checks++; if ({sca_waddr, sca_first, sca_last} !== {exp_wa, (c == 8), (c == 9)}) begin errors++; $display("FAIL abort_newjob c=%0d got %h %b%b exp %h %b%b", c, sca_waddr, sca_first, sca_last, exp_wa, (c == 8), (c == 9)); end
         end
      end
      cfg_start = 1'b0; in_valid = 1'b0; sca_valid_out = 1'b0;
   endtask

   task automatic test_back_to_back;
      start_job(10'd1, 6'd1, 12'h055);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         in_valid = (c == 1); sca_valid_out = (c == 2); cfg_start = (c == 3 || c == 4);
         if (c == 3) cfg_n_tiles = 10'd0;
         #1;
         checks++; if (sca_valid !== (c == 1)) begin errors++; $display("FAIL b2b_fire c=%0d got %b exp %b", c, sca_valid, (c == 1)); end
         if (c == 1) begin
            checks++; if ({sca_first, sca_last, sca_waddr} !== {2'b11, 12'h055}) begin errors++; $display("FAIL b2b_beat got %b%b %h exp 11 055", sca_first, sca_last, sca_waddr); end
         end
         checks++; if (done !== (c == 3 || c == 5)) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, (c == 3 || c == 5)); end
         checks++; if (busy !== (c != 4 && c != 6)) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, (c != 4 && c != 6)); end
      end
      cfg_start = 1'b0; in_valid = 1'b0; sca_valid_out = 1'b0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_inflight;
      test_stall;
      test_wrap;
      test_empty_err;
      test_abort;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
